camera_capture_window: RTL and testbench

- Parametrised DVP capture front-end for the OV7670 path.
- Samples the camera byte stream on the pixel clock and assembles 1- or 2-byte pixels.
- Applies a static crop window and power-of-two decimation, then pushes tagged words into the downstream pixel queue.
- Adds backpressure and overflow handling, per-line tagging and frame statistics on top of the existing capture behaviour.

---
 rtl/camera_capture_window.sv | 211 +++++++++++++++++++++
 tb/tb_camera_capture_window.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture_window.sv
`default_nettype none
// ============================================================================
// camera_capture_window : DVP byte capture with crop, decimation, tagged queue writes
// Revision: 1.0
// ============================================================================
module camera_capture_window #(
  parameter int unsigned BYTE_W          = 8,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned CROP_X0         = 0,
  parameter int unsigned CROP_Y0         = 0,
  parameter int unsigned CROP_W          = 640,
  parameter int unsigned CROP_H          = 480,
  parameter int unsigned DECIM_LOG2      = 0,
  parameter int unsigned CNT_W           = 11,
  localparam int unsigned PIX_W          = BYTES_PER_PIXEL * BYTE_W
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [BYTE_W-1:0] p_data,
  input  logic              init_done,
  input  logic              byte_swap,
  input  logic              queue_full,
  output logic              queue_clk,
  output logic [PIX_W+1:0]  queue_data,
  output logic              queue_wr_en,
  output logic [15:0]       frame_count,
  output logic              overflow,
  output logic              frame_dropped
);

  localparam logic [2:0] S_WAIT_CAL    = 3'd0;
  localparam logic [2:0] S_WAIT_VS_HI  = 3'd1;
  localparam logic [2:0] S_WAIT_FS     = 3'd2;
  localparam logic [2:0] S_FRAME_MARK  = 3'd3;
  localparam logic [2:0] S_ROW         = 3'd4;
  localparam logic [2:0] S_DROP        = 3'd5;

  localparam logic [CNT_W-1:0] DEC_MASK = CNT_W'((1 << DECIM_LOG2) - 1);

  logic [2:0]        state_q, state_d;
  logic              swap_q, swap_d;
  logic              phase_q, phase_d;
  logic [BYTE_W-1:0] first_q, first_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic              href_q, href_d;
  logic              line_kept_q, line_kept_d;
  logic              pend_q, pend_d;
  logic [PIX_W+1:0]  pix_q, pix_d;
  logic              dropped_q, dropped_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              overflow_q, overflow_d;
  logic              frame_dropped_q, frame_dropped_d;

  logic [PIX_W-1:0]  pixel_w;
  logic              last_byte_w;
  logic [CNT_W-1:0]  col_off_w, row_off_w;
  logic              keep_w, drop_w, capture_w, line_end_w, frame_end_w;

  generate
    if (BYTES_PER_PIXEL == 2) begin : g_two_byte
      assign pixel_w     = swap_q ? {p_data, first_q} : {first_q, p_data};
      assign last_byte_w = phase_q;
    end else begin : g_one_byte
      assign pixel_w     = p_data;
      assign last_byte_w = 1'b1;
    end
  endgenerate

  assign col_off_w = col_q - CNT_W'(CROP_X0);
  assign row_off_w = row_q - CNT_W'(CROP_Y0);
  assign keep_w = (32'(col_q) >= CROP_X0) && (32'(col_q) < CROP_X0 + CROP_W) &&
                  (32'(row_q) >= CROP_Y0) && (32'(row_q) < CROP_Y0 + CROP_H) &&
                  ((col_off_w & DEC_MASK) == '0) && ((row_off_w & DEC_MASK) == '0);

  // A completed pixel waits one cycle in pix_q; it is lost if the queue is full then.
  assign drop_w      = pend_q && queue_full;
  assign capture_w   = (state_q == S_ROW) && !cam_vsync && cam_href && !drop_w;
  assign line_end_w  = (state_q == S_ROW) && !cam_vsync && href_q && !cam_href;
  assign frame_end_w = ((state_q == S_ROW) || (state_q == S_DROP)) && cam_vsync;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_WAIT_CAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_CAL:   if (init_done) state_d = S_WAIT_VS_HI;
      S_WAIT_VS_HI: if (cam_vsync) state_d = S_WAIT_FS;
      S_WAIT_FS:    if (!cam_vsync) state_d = S_FRAME_MARK;
      S_FRAME_MARK: begin
        if (cam_vsync)        state_d = S_WAIT_FS;
        else if (!queue_full) state_d = S_ROW;
      end
      S_ROW: begin
        if (cam_vsync)   state_d = S_WAIT_FS;
        else if (drop_w) state_d = S_DROP;
      end
      S_DROP:       if (cam_vsync) state_d = S_WAIT_FS;
      default:      state_d = S_WAIT_CAL;
    endcase
  end

  always_comb begin
    queue_data  = pix_q;
    queue_wr_en = pend_q && !queue_full;
    if (state_q == S_FRAME_MARK) begin
      queue_data  = {1'b1, 1'b0, {PIX_W{1'b0}}};
      queue_wr_en = !cam_vsync && !queue_full;
    end
  end

  always_comb begin
    swap_d          = swap_q;
    phase_d         = phase_q;
    first_d         = first_q;
    col_d           = col_q;
    row_d           = row_q;
    href_d          = cam_href && (state_q == S_ROW);
    line_kept_d     = line_kept_q;
    pend_d          = 1'b0;
    pix_d           = pix_q;
    dropped_d       = dropped_q;
    frame_count_d   = frame_count_q;
    overflow_d      = overflow_q || drop_w;
    frame_dropped_d = 1'b0;

    if ((state_q == S_WAIT_FS) && !cam_vsync) begin
      swap_d      = byte_swap;
      phase_d     = 1'b0;
      col_d       = '0;
      row_d       = '0;
      line_kept_d = 1'b0;
      dropped_d   = 1'b0;
    end

    if (capture_w) begin
      if (last_byte_w) begin
        phase_d = 1'b0;
        col_d   = (col_q == '1) ? col_q : col_q + 1'b1;
        if (keep_w) begin
          pend_d      = 1'b1;
          pix_d       = {1'b0, !line_kept_q, pixel_w};
          line_kept_d = 1'b1;
        end
      end else begin
        phase_d = 1'b1;
        first_d = p_data;
      end
    end else if (line_end_w) begin
      row_d       = (row_q == '1) ? row_q : row_q + 1'b1;
      col_d       = '0;
      phase_d     = 1'b0;
      line_kept_d = 1'b0;
    end

    if (frame_end_w) begin
      if (dropped_q || drop_w) frame_dropped_d = 1'b1;
      else                     frame_count_d   = frame_count_q + 16'd1;
      dropped_d = 1'b0;
    end else if (drop_w) begin
      dropped_d = 1'b1;
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      swap_q          <= 1'b0;
      phase_q         <= 1'b0;
      first_q         <= '0;
      col_q           <= '0;
      row_q           <= '0;
      href_q          <= 1'b0;
      line_kept_q     <= 1'b0;
      pend_q          <= 1'b0;
      pix_q           <= '0;
      dropped_q       <= 1'b0;
      frame_count_q   <= '0;
      overflow_q      <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      swap_q          <= swap_d;
      phase_q         <= phase_d;
      first_q         <= first_d;
      col_q           <= col_d;
      row_q           <= row_d;
      href_q          <= href_d;
      line_kept_q     <= line_kept_d;
      pend_q          <= pend_d;
      pix_q           <= pix_d;
      dropped_q       <= dropped_d;
      frame_count_q   <= frame_count_d;
      overflow_q      <= overflow_d;
      frame_dropped_q <= frame_dropped_d;
    end
  end

  assign queue_clk     = PixelClk;
  assign frame_count   = frame_count_q;
  assign overflow      = overflow_q;
  assign frame_dropped = frame_dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_capture_window.sv
`default_nettype none
// ============================================================================
// tb_camera_capture_window : scoreboard bench for default, cropped and decimated captures
// Revision: 1.0
// ============================================================================
module tb_camera_capture_window;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        init_done;
  logic        vs   [N];
  logic        hr   [N];
  logic [7:0]  pd   [N];
  logic        swp  [N];
  logic        qf   [N];
  logic        qclk [N];
  logic [17:0] qd   [N];
  logic        wr   [N];
  logic [15:0] fc   [N];
  logic        ov   [N];
  logic        fd   [N];

  always #5 clk = ~clk;

  camera_capture_window u_dut_default (
    .PixelClk(clk), .nRST(nrst), .cam_vsync(vs[0]), .cam_href(hr[0]), .p_data(pd[0]),
    .init_done(init_done), .byte_swap(swp[0]), .queue_full(qf[0]), .queue_clk(qclk[0]),
    .queue_data(qd[0]), .queue_wr_en(wr[0]), .frame_count(fc[0]), .overflow(ov[0]),
    .frame_dropped(fd[0]));

  camera_capture_window #(.CROP_X0(1), .CROP_W(2), .CROP_Y0(1), .CROP_H(1), .DECIM_LOG2(0)) u_dut_crop (
    .PixelClk(clk), .nRST(nrst), .cam_vsync(vs[1]), .cam_href(hr[1]), .p_data(pd[1]),
    .init_done(init_done), .byte_swap(swp[1]), .queue_full(qf[1]), .queue_clk(qclk[1]),
    .queue_data(qd[1]), .queue_wr_en(wr[1]), .frame_count(fc[1]), .overflow(ov[1]),
    .frame_dropped(fd[1]));

  camera_capture_window #(.DECIM_LOG2(1)) u_dut_decim (
    .PixelClk(clk), .nRST(nrst), .cam_vsync(vs[2]), .cam_href(hr[2]), .p_data(pd[2]),
    .init_done(init_done), .byte_swap(swp[2]), .queue_full(qf[2]), .queue_clk(qclk[2]),
    .queue_data(qd[2]), .queue_wr_en(wr[2]), .frame_count(fc[2]), .overflow(ov[2]),
    .frame_dropped(fd[2]));

  logic [17:0] exp0 [$];
  logic [17:0] exp1 [$];
  logic [17:0] exp2 [$];

  int          snap_id   = 0;
  int          snap_kind = 0;
  int          snap_k    = 0;
  logic [63:0] snap_exp  = '0;
  logic        done      = 1'b0;

  int          checks    = 0;
  int          fails     = 0;
  int          snap_seen = 0;
  int          drops [N] = '{default: 0};

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input logic [17:0] v);
    case (k)
      0:       exp0.push_back(v);
      1:       exp1.push_back(v);
      default: exp2.push_back(v);
    endcase
  endtask

  task automatic send_line(input int k, input logic [7:0] b[$], input int qf_idx);
    foreach (b[i]) begin
      hr[k] = 1'b1;
      pd[k] = b[i];
      qf[k] = (i == qf_idx);
      tick(1);
    end
    hr[k] = 1'b0;
    qf[k] = 1'b0;
    tick(3);
  endtask

  task automatic frame_start(input int k);
    vs[k] = 1'b1;
    tick(3);
    vs[k] = 1'b0;
    tick(2);
  endtask

  task automatic frame_end(input int k);
    vs[k] = 1'b1;
    tick(3);
  endtask

  task automatic snap(input int kind, input int k, input logic [63:0] e);
    snap_kind = kind;
    snap_k    = k;
    snap_exp  = e;
    snap_id   = snap_id + 1;
    tick(1);
  endtask

  function automatic logic [63:0] status(input int f, input int o, input int d);
    return {39'd0, 16'(f), 1'(o), 8'(d)};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic check_write(input int k);
    logic [17:0] e;
    int          n;
    checks++;
    if (qf[k] !== 1'b0) begin
      fails++;
      $display("FAIL write_while_full dut%0d: got wr_en=1 with queue_full=1, need wr_en=0", k);
    end
    checks++;
    n = (k == 0) ? exp0.size() : (k == 1) ? exp1.size() : exp2.size();
    if (n == 0) begin
      fails++;
      $display("FAIL unexpected_write dut%0d: got data=%05h, need no write", k, qd[k]);
    end else begin
      case (k)
        0:       e = exp0.pop_front();
        1:       e = exp1.pop_front();
        default: e = exp2.pop_front();
      endcase
      if (qd[k] !== e) begin
        fails++;
        $display("FAIL write_data dut%0d: got %05h, need %05h", k, qd[k], e);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] act;
    for (int k = 0; k < N; k++) begin
      if (wr[k] === 1'b1) check_write(k);
      if (fd[k] === 1'b1) drops[k] = drops[k] + 1;
    end
    if (snap_id != snap_seen) begin
      snap_seen = snap_id;
      if (snap_kind == 0)
        act = {26'd0, qclk[snap_k], wr[snap_k], qd[snap_k], fc[snap_k], ov[snap_k], fd[snap_k]};
      else
        act = {39'd0, fc[snap_k], ov[snap_k], 8'(drops[snap_k])};
      checks++;
      if (act !== snap_exp) begin
        fails++;
        $display("FAIL %s dut%0d: got %h, need %h",
                 (snap_kind == 0) ? "reset_state" : "frame_status", snap_k, act, snap_exp);
      end
    end
    if (done) begin
      checks++;
      if (exp0.size() != 0) begin
        fails++;
        $display("FAIL missing_writes dut0: got %0d outstanding, need 0", exp0.size());
      end
      checks++;
      if (exp1.size() != 0) begin
        fails++;
        $display("FAIL missing_writes dut1: got %0d outstanding, need 0", exp1.size());
      end
      checks++;
      if (exp2.size() != 0) begin
        fails++;
        $display("FAIL missing_writes dut2: got %0d outstanding, need 0", exp2.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end, need completion within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] ln [$];
    nrst      = 1'b1;
    init_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      vs[k] = 1'b0; hr[k] = 1'b0; pd[k] = 8'h00; swp[k] = 1'b0; qf[k] = 1'b0;
    end
    #2 nrst = 1'b0;
    tick(2);
    snap(0, 0, 64'd0);

    // calibration done while vsync low: a line now must not be captured
    nrst = 1'b1;
    init_done = 1'b1;
    tick(2);
    ln = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_line(0, ln, -1);

    // frame A: normal byte order, two lines of four pixels
    push_exp(0, 18'h20000);
    push_exp(0, 18'h1AABB); push_exp(0, 18'h0CCDD); push_exp(0, 18'h0EEFF); push_exp(0, 18'h01122);
    push_exp(0, 18'h13344); push_exp(0, 18'h05566); push_exp(0, 18'h07788); push_exp(0, 18'h09900);
    frame_start(0);
    init_done = 1'b0;
    ln = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22};
    send_line(0, ln, -1);
    ln = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h00};
    send_line(0, ln, -1);
    frame_end(0);
    snap(1, 0, status(1, 0, 0));

    // frame B: swapped bytes, swap input changed mid-frame
    swp[0] = 1'b1;
    push_exp(0, 18'h20000);
    push_exp(0, 18'h13412); push_exp(0, 18'h07856); push_exp(0, 18'h1BC9A);
    frame_start(0);
    ln = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_line(0, ln, -1);
    swp[0] = 1'b0;
    ln = '{8'h9A, 8'hBC};
    send_line(0, ln, -1);
    frame_end(0);
    snap(1, 0, status(2, 0, 0));

    // frame C: queue full on the third pixel drops the rest of the frame
    push_exp(0, 18'h20000);
    push_exp(0, 18'h1C0C1); push_exp(0, 18'h0C2C3);
    frame_start(0);
    ln = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    send_line(0, ln, 6);
    ln = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    send_line(0, ln, -1);
    frame_end(0);
    snap(1, 0, status(2, 1, 1));

    // frame D: marker held by queue_full, odd byte count on first line
    push_exp(0, 18'h20000);
    push_exp(0, 18'h10102); push_exp(0, 18'h00304); push_exp(0, 18'h10607);
    vs[0] = 1'b1;
    tick(3);
    vs[0] = 1'b0;
    qf[0] = 1'b1;
    tick(2);
    qf[0] = 1'b0;
    tick(2);
    ln = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_line(0, ln, -1);
    ln = '{8'h06, 8'h07};
    send_line(0, ln, -1);
    frame_end(0);
    snap(1, 0, status(3, 1, 1));

    // frame E: reset asserted mid-line
    push_exp(0, 18'h20000);
    push_exp(0, 18'h1A1B2);
    frame_start(0);
    hr[0] = 1'b1;
    pd[0] = 8'hA1; tick(1);
    pd[0] = 8'hB2; tick(1);
    pd[0] = 8'hC3; tick(1);
    nrst = 1'b0;
    tick(2);
    snap(0, 0, 64'd0);
    hr[0] = 1'b0;
    nrst  = 1'b1;
    tick(2);

    // no capture without init_done, nor before a fresh vsync high->low
    frame_start(0);
    ln = '{8'h21, 8'h22};
    send_line(0, ln, -1);
    frame_end(0);
    vs[0] = 1'b0;
    tick(2);
    init_done = 1'b1;
    tick(2);
    ln = '{8'h31, 8'h32};
    send_line(0, ln, -1);
    push_exp(0, 18'h20000);
    push_exp(0, 18'h15AA5);
    frame_start(0);
    ln = '{8'h5A, 8'hA5};
    send_line(0, ln, -1);
    frame_end(0);
    snap(1, 0, status(1, 0, 1));

    // crop instance: 3 rows x 4 pixels, keep row 1 columns 1..2
    push_exp(1, 18'h20000);
    push_exp(1, 18'h121A1); push_exp(1, 18'h022A2);
    frame_start(1);
    for (int r = 0; r < 3; r++) begin
      ln.delete();
      for (int c = 0; c < 4; c++) begin
        ln.push_back(8'(16 * (r + 1) + c));
        ln.push_back(8'(16 * (r + 1) + c + 128));
      end
      send_line(1, ln, -1);
    end
    frame_end(1);
    snap(1, 1, status(1, 0, 0));

    // decimate-by-2 instance: 4 rows x 4 pixels, keep rows/cols 0 and 2
    push_exp(2, 18'h20000);
    push_exp(2, 18'h11090); push_exp(2, 18'h01292);
    push_exp(2, 18'h130B0); push_exp(2, 18'h032B2);
    frame_start(2);
    for (int r = 0; r < 4; r++) begin
      ln.delete();
      for (int c = 0; c < 4; c++) begin
        ln.push_back(8'(16 * (r + 1) + c));
        ln.push_back(8'(16 * (r + 1) + c + 128));
      end
      send_line(2, ln, -1);
    end
    frame_end(2);
    snap(1, 2, status(1, 0, 0));

    done = 1'b1;
    tick(3);
  end

endmodule
`default_nettype wire
